mii_hex_uart_bridge: RTL and testbench

- Multi-channel successor to the single-port MII capture path.
- Captures bytes from CHANNELS MIIcore-style byte sources into per-channel FIFOs and arbitrates round-robin at frame granularity.
- Formats each byte as two lowercase hex ASCII chars plus a separator, and drives a uart_tx-style byte/dv/active handshake.
- Sits between the MIIcore instances and the single debug UART transmitter.

---
 rtl/mii_hex_uart_bridge.sv | 213 +++++++++++++++++++++
 tb/tb_mii_hex_uart_bridge.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mii_hex_uart_bridge.sv
// Captures bytes from CHANNELS MII byte sources into per-channel FIFOs and streams them as hex ASCII
// to a UART, one frame at a time. Define MII_HEX_UART_CHANNEL_TAG_EN to prefix each frame with "c:".
module mii_hex_uart_bridge #(
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CHANNELS-1:0]   in_valid,
    input  logic [CHANNELS-1:0]   in_last,
    input  logic [8*CHANNELS-1:0] in_data,
    output logic [7:0]            tx_data,
    output logic                  tx_dv,
    input  logic                  tx_active,
    output logic [CHANNELS-1:0]   overflow,
    output logic                  busy
);
    localparam int unsigned Depth = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2 + 1;
    localparam int unsigned CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
`ifdef MII_HEX_UART_CHANNEL_TAG_EN
    localparam bit TagEn = 1'b1;
`else
    localparam bit TagEn = 1'b0;
`endif

    typedef enum logic [2:0] {StIdle, StFetch, StEmit, StWaitHi, StWaitLo} state_e;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : (8'h57 + {4'h0, n});
    endfunction

    // Capture stage and FIFOs
    logic [CHANNELS-1:0]        prev_q, cap_q, cap_last_q;
    logic [CHANNELS-1:0][7:0]   cap_data_q;
    logic [CHANNELS-1:0][PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [8:0]                 mem_q [CHANNELS][Depth];
    logic [CHANNELS-1:0]        full, empty, qual;
    logic [CHANNELS-1:0]        overflow_q, force_eol_q;

    // Formatter
    state_e           state_q, state_d;
    logic [CW-1:0]    lock_q, lock_d, rr_q, rr_d, scan_ch;
    logic [CW:0]      cand;
    logic             found, pop, eol_clr, advance;
    logic [5:0][7:0]  seq_q, byte_seq;
    logic [2:0]       idx_q, len_q, byte_len, base;
    logic             end_q, first_q;
    logic [8:0]       head;

    always_comb begin
        empty = '0;
        full  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            empty[c] = wr_ptr_q[c] == rd_ptr_q[c];
            full[c]  = (wr_ptr_q[c][PW-1] != rd_ptr_q[c][PW-1]) &&
                       (wr_ptr_q[c][PW-2:0] == rd_ptr_q[c][PW-2:0]);
        end
        qual = ~empty | force_eol_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q      <= '0;
            cap_q       <= '0;
            cap_last_q  <= '0;
            cap_data_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= '0;
            force_eol_q <= '0;
        end else begin
            prev_q     <= in_valid;
            cap_q      <= in_valid & ~prev_q;
            cap_last_q <= in_last;
            cap_data_q <= in_data;
            for (int c = 0; c < CHANNELS; c++) begin
                if (cap_q[c]) begin
                    if (!full[c]) begin
                        wr_ptr_q[c] <= wr_ptr_q[c] + PW'(1);
                    end else begin
                        overflow_q[c] <= 1'b1;
                        // A dropped frame end must still terminate the line.
                        if (cap_last_q[c]) force_eol_q[c] <= 1'b1;
                    end
                end
            end
            if (pop) rd_ptr_q[lock_q] <= rd_ptr_q[lock_q] + PW'(1);
            if (eol_clr) force_eol_q[lock_q] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (cap_q[c] && !full[c]) begin
                mem_q[c][wr_ptr_q[c][DEPTH_LOG2-1:0]] <= {cap_last_q[c], cap_data_q[c]};
            end
        end
    end

    always_comb begin
        head     = mem_q[lock_q][rd_ptr_q[lock_q][DEPTH_LOG2-1:0]];
        byte_seq = '0;
        byte_len = '0;
        base     = '0;
        if (TagEn && first_q) begin
            byte_seq[0] = hex_char(4'(lock_q));
            byte_seq[1] = 8'h3A;
            base        = 3'd2;
        end
        byte_seq[base]        = hex_char(head[7:4]);
        byte_seq[base + 3'd1] = hex_char(head[3:0]);
        if (head[8]) begin
            byte_seq[base + 3'd2] = 8'h0D;
            byte_seq[base + 3'd3] = 8'h0A;
            byte_len              = base + 3'd4;
        end else begin
            byte_seq[base + 3'd2] = 8'h20;
            byte_len              = base + 3'd3;
        end
    end

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        rr_d    = rr_q;
        pop     = 1'b0;
        eol_clr = 1'b0;
        advance = 1'b0;
        found   = 1'b0;
        scan_ch = '0;
        cand    = '0;
        // Descending scan so the lowest offset from rr_q wins.
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            cand = {1'b0, rr_q} + (CW+1)'(i);
            if (cand >= (CW+1)'(CHANNELS)) cand = cand - (CW+1)'(CHANNELS);
            if (qual[cand[CW-1:0]]) begin
                found   = 1'b1;
                scan_ch = cand[CW-1:0];
            end
        end
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    lock_d  = scan_ch;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (!empty[lock_q]) begin
                    pop     = 1'b1;
                    state_d = StEmit;
                end else if (force_eol_q[lock_q]) begin
                    eol_clr = 1'b1;
                    state_d = StEmit;
                end
            end
            StEmit:   state_d = StWaitHi;
            StWaitHi: if (tx_active) state_d = StWaitLo;
            StWaitLo: begin
                if (!tx_active) begin
                    if (idx_q + 3'd1 < len_q) begin
                        advance = 1'b1;
                        state_d = StEmit;
                    end else if (end_q) begin
                        rr_d    = (lock_q == CW'(CHANNELS - 1)) ? '0 : lock_q + CW'(1);
                        state_d = StIdle;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            lock_q  <= '0;
            rr_q    <= '0;
            seq_q   <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            end_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            rr_q    <= rr_d;
            if (state_q == StIdle && found) first_q <= 1'b1;
            if (pop) begin
                seq_q   <= byte_seq;
                len_q   <= byte_len;
                idx_q   <= '0;
                end_q   <= head[8];
                first_q <= 1'b0;
            end else if (eol_clr) begin
                seq_q <= {32'h0, 8'h0A, 8'h0D};
                len_q <= 3'd2;
                idx_q <= '0;
                end_q <= 1'b1;
            end
            if (advance) idx_q <= idx_q + 3'd1;
        end
    end

    assign tx_data  = seq_q[idx_q];
    assign tx_dv    = state_q == StEmit;
    assign busy     = state_q != StIdle;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_mii_hex_uart_bridge.sv
// Scoreboard bench for mii_hex_uart_bridge: expected chars queued as bytes are driven, popped on tx_dv.
module tb_mii_hex_uart_bridge;
    localparam int CHANNELS   = 2;
    localparam int DEPTH_LOG2 = 6;
`ifdef MII_HEX_UART_CHANNEL_TAG_EN
    localparam bit TagEn = 1'b1;
`else
    localparam bit TagEn = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic [CHANNELS-1:0]   in_valid, in_last;
    logic [8*CHANNELS-1:0] in_data;
    logic [7:0]            tx_data;
    logic                  tx_dv, tx_active, busy;
    logic [CHANNELS-1:0]   overflow;

    typedef struct {
        int         ch;
        logic [7:0] data;
        bit         last;
        logic [7:0] c0;
        logic [7:0] c1;
    } vec_t;

    vec_t          vecs [7];
    logic [7:0]    exp_q [$];
    int            checks = 0;
    int            failures = 0;
    int            busy_cnt = 0;
    bit            stall = 1'b0;
    bit            mute = 1'b0;
    bit [CHANNELS-1:0] in_frame = '0;

    always #5 clk = ~clk;

    mii_hex_uart_bridge #(.CHANNELS(CHANNELS), .DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data   (in_data),
        .tx_data   (tx_data),
        .tx_dv     (tx_dv),
        .tx_active (tx_active),
        .overflow  (overflow),
        .busy      (busy)
    );

    function automatic logic [7:0] hex(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h61 + {4'h0, n} - 8'd10);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tag(input int ch);
        if (TagEn && !in_frame[ch]) begin
            exp_q.push_back(hex(ch[3:0]));
            exp_q.push_back(8'h3A);
        end
    endtask

    task automatic push_sep(input int ch, input bit last);
        if (last) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end else begin
            exp_q.push_back(8'h20);
        end
        in_frame[ch] = !last;
    endtask

    task automatic push_byte(input int ch, input logic [7:0] d, input bit last);
        push_tag(ch);
        exp_q.push_back(hex(d[7:4]));
        exp_q.push_back(hex(d[3:0]));
        push_sep(ch, last);
    endtask

    task automatic send_byte(input int ch, input logic [7:0] d, input bit last);
        in_data[8*ch +: 8] = d;
        in_last[ch]        = last;
        in_valid[ch]       = 1'b1;
        step();
        in_valid[ch] = 1'b0;
        step();
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy_cnt != 0) && n < budget) begin
            step();
            n++;
        end
        step();
        step();
        check({name, "_drain_in_time"}, 32'(n < budget), 32'd1);
        if (n >= budget) exp_q.delete();
    endtask

    // UART model: 10-cycle busy after each tx_dv; stall forces busy, mute forces idle.
    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (tx_dv === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL tx_char: got %h, required no output", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        failures++;
                        $display("FAIL tx_char: got %h, required %h", tx_data, e);
                    end
                end
                busy_cnt = 10;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
            end
            tx_active = !mute && (stall || busy_cnt != 0);
        end
    endtask

    initial begin
        int n;
        int sz;
        vecs[0] = '{0, 8'hA5, 1'b0, "a", "5"};
        vecs[1] = '{0, 8'h3C, 1'b1, "3", "c"};
        vecs[2] = '{1, 8'h0F, 1'b1, "0", "f"};
        vecs[3] = '{1, 8'h90, 1'b0, "9", "0"};
        vecs[4] = '{1, 8'hEB, 1'b1, "e", "b"};
        vecs[5] = '{0, 8'h00, 1'b0, "0", "0"};
        vecs[6] = '{0, 8'hFF, 1'b1, "f", "f"};

        reset     = 1'b1;
        in_valid  = '0;
        in_last   = '0;
        in_data   = '0;
        tx_active = 1'b0;
        fork
            monitor();
        join_none
        repeat (3) step();
        check("reset_tx_data", tx_data, 0);
        check("reset_tx_dv", tx_dv, 0);
        check("reset_overflow", overflow, 0);
        check("reset_busy", busy, 0);
        reset = 1'b0;
        step();

        // First tx_dv four cycles after the in_valid rising edge.
        push_byte(0, 8'h42, 1'b1);
        in_data[7:0] = 8'h42;
        in_last[0]   = 1'b1;
        in_valid[0]  = 1'b1;
        step();
        check("latency_c1", tx_dv, 0);
        in_valid[0] = 1'b0;
        step();
        check("latency_c2", tx_dv, 0);
        step();
        check("latency_c3", tx_dv, 0);
        step();
        check("latency_c4", tx_dv, 1);
        drain(200, "latency");
        check("latency_idle", busy, 0);

        for (int i = 0; i < 7; i++) begin
            push_tag(vecs[i].ch);
            exp_q.push_back(vecs[i].c0);
            exp_q.push_back(vecs[i].c1);
            push_sep(vecs[i].ch, vecs[i].last);
            send_byte(vecs[i].ch, vecs[i].data, vecs[i].last);
            if (vecs[i].last) begin
                drain(300, "table");
                check("table_idle", busy, 0);
            end
        end

        // Level held high for 20 cycles captures once; channel then stays locked.
        push_byte(0, 8'h11, 1'b0);
        in_data[7:0] = 8'h11;
        in_last[0]   = 1'b0;
        in_valid[0]  = 1'b1;
        repeat (20) step();
        in_valid[0] = 1'b0;
        step();
        drain(200, "hold");
        check("hold_locked", busy, 1);
        push_byte(0, 8'h22, 1'b1);
        send_byte(0, 8'h22, 1'b1);
        drain(200, "hold_close");
        check("hold_idle", busy, 0);

        // ch1 frames queued first while ch1 holds the UART; ch0 frame must win next.
        stall = 1'b1;
        push_byte(1, 8'h77, 1'b1);
        send_byte(1, 8'h77, 1'b1);
        send_byte(1, 8'h01, 1'b0);
        send_byte(1, 8'h02, 1'b1);
        send_byte(0, 8'h0A, 1'b0);
        send_byte(0, 8'h0B, 1'b1);
        push_byte(0, 8'h0A, 1'b0);
        push_byte(0, 8'h0B, 1'b1);
        push_byte(1, 8'h01, 1'b0);
        push_byte(1, 8'h02, 1'b1);
        stall = 1'b0;
        drain(600, "arb");
        // Round-robin pointer back at ch0: simultaneous frames go ch0 then ch1.
        push_byte(0, 8'hC0, 1'b1);
        push_byte(1, 8'hC1, 1'b1);
        in_data     = {8'hC1, 8'hC0};
        in_last     = 2'b11;
        in_valid    = 2'b11;
        step();
        in_valid = 2'b00;
        step();
        drain(400, "rr");
        check("rr_idle", busy, 0);

        // Fill ch0 FIFO behind a stalled ch1 frame; 65th byte (last) is dropped.
        stall = 1'b1;
        push_byte(1, 8'h55, 1'b1);
        send_byte(1, 8'h55, 1'b1);
        for (int i = 0; i < 64; i++) begin
            push_byte(0, 8'(i), 1'b0);
            send_byte(0, 8'(i), 1'b0);
        end
        check("full_no_overflow", overflow, 0);
        send_byte(0, 8'hEE, 1'b1);
        step();
        check("overflow_set", overflow, 2'b01);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        in_frame[0] = 1'b0;
        stall = 1'b0;
        drain(5000, "overflow");
        check("overflow_sticky", overflow, 2'b01);
        check("overflow_idle", busy, 0);

        // Reset while waiting for the UART to start char 2.
        push_byte(0, 8'h9A, 1'b1);
        sz = exp_q.size();
        send_byte(0, 8'h9A, 1'b1);
        n = 0;
        while (!(tx_dv === 1'b1 && exp_q.size() == sz - 1) && n < 100) begin
            step();
            n++;
        end
        check("char2_seen", 32'(n < 100), 32'd1);
        mute = 1'b1;
        step();
        step();
        check("wait_hi_busy", busy, 1);
        reset = 1'b1;
        step();
        check("midreset_tx_dv", tx_dv, 0);
        check("midreset_busy", busy, 0);
        check("midreset_overflow", overflow, 0);
        reset    = 1'b0;
        exp_q.delete();
        busy_cnt = 0;
        in_frame = '0;
        mute     = 1'b0;
        step();
        push_byte(1, 8'h5E, 1'b1);
        send_byte(1, 8'h5E, 1'b1);
        drain(300, "post_reset");
        check("post_reset_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
